// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the timing generator and its display/fetch consumers.
interface vga_timing_gen_if #(
    parameter int unsigned COORD_W = 11
);
    logic               enable;
    logic               mode_sel;
    logic               mode_active;
    logic               fetch_valid;
    logic [COORD_W-1:0] fetch_x;
    logic [COORD_W-1:0] fetch_y;
    logic               h_sync;
    logic               v_sync;
    logic               disp_ena;
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
    logic               line_start;
    logic               frame_start;
    logic [15:0]        frame_count;

    // Generator side: takes run/mode controls, drives all timing outputs.
    modport master (
        input  enable, mode_sel,
        output mode_active, fetch_valid, fetch_x, fetch_y, h_sync, v_sync, disp_ena,
               column, row, line_start, frame_start, frame_count
    );

    // Consumer side.
    modport slave (
        output enable, mode_sel,
        input  mode_active, fetch_valid, fetch_x, fetch_y, h_sync, v_sync, disp_ena,
               column, row, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator with a lookahead fetch stage and a PIPE_DELAY-deep
// display pipeline, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int unsigned COORD_W    = 11,
    parameter int unsigned PIPE_DELAY = 1,
    parameter int unsigned A_H_PIX    = 640,
    parameter int unsigned A_H_FP     = 16,
    parameter int unsigned A_H_PULSE  = 96,
    parameter int unsigned A_H_BP     = 48,
    parameter int unsigned A_V_PIX    = 480,
    parameter int unsigned A_V_FP     = 10,
    parameter int unsigned A_V_PULSE  = 2,
    parameter int unsigned A_V_BP     = 33,
    parameter bit          A_H_POL    = 1'b0,
    parameter bit          A_V_POL    = 1'b0,
    parameter int unsigned B_H_PIX    = 800,
    parameter int unsigned B_H_FP     = 56,
    parameter int unsigned B_H_PULSE  = 120,
    parameter int unsigned B_H_BP     = 64,
    parameter int unsigned B_V_PIX    = 600,
    parameter int unsigned B_V_FP     = 37,
    parameter int unsigned B_V_PULSE  = 6,
    parameter int unsigned B_V_BP     = 23,
    parameter bit          B_H_POL    = 1'b1,
    parameter bit          B_V_POL    = 1'b1
) (
    input logic              pixel_clk,
    input logic              reset,
    vga_timing_gen_if.master vga
);
    localparam int PD = int'(PIPE_DELAY);

    // Per-mode decode points: active width, sync start, sync end (inclusive), last count.
    localparam logic [COORD_W-1:0] A_HPX = COORD_W'(A_H_PIX);
    localparam logic [COORD_W-1:0] A_HSS = COORD_W'(A_H_PIX + A_H_FP);
    localparam logic [COORD_W-1:0] A_HSE = COORD_W'(A_H_PIX + A_H_FP + A_H_PULSE - 1);
    localparam logic [COORD_W-1:0] A_HLS = COORD_W'(A_H_PIX + A_H_FP + A_H_PULSE + A_H_BP - 1);
    localparam logic [COORD_W-1:0] A_VPX = COORD_W'(A_V_PIX);
    localparam logic [COORD_W-1:0] A_VSS = COORD_W'(A_V_PIX + A_V_FP);
    localparam logic [COORD_W-1:0] A_VSE = COORD_W'(A_V_PIX + A_V_FP + A_V_PULSE - 1);
    localparam logic [COORD_W-1:0] A_VLS = COORD_W'(A_V_PIX + A_V_FP + A_V_PULSE + A_V_BP - 1);
    localparam logic [COORD_W-1:0] B_HPX = COORD_W'(B_H_PIX);
    localparam logic [COORD_W-1:0] B_HSS = COORD_W'(B_H_PIX + B_H_FP);
    localparam logic [COORD_W-1:0] B_HSE = COORD_W'(B_H_PIX + B_H_FP + B_H_PULSE - 1);
    localparam logic [COORD_W-1:0] B_HLS = COORD_W'(B_H_PIX + B_H_FP + B_H_PULSE + B_H_BP - 1);
    localparam logic [COORD_W-1:0] B_VPX = COORD_W'(B_V_PIX);
    localparam logic [COORD_W-1:0] B_VSS = COORD_W'(B_V_PIX + B_V_FP);
    localparam logic [COORD_W-1:0] B_VSE = COORD_W'(B_V_PIX + B_V_FP + B_V_PULSE - 1);
    localparam logic [COORD_W-1:0] B_VLS = COORD_W'(B_V_PIX + B_V_FP + B_V_PULSE + B_V_BP - 1);

    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               hs;
        logic               vs;
        logic               ls;
        logic               fs;
    } stage_t;

    localparam stage_t RST_STAGE = '{valid: 1'b0, x: '0, y: '0, hs: ~A_H_POL, vs: ~A_V_POL,
                                     ls: 1'b0, fs: 1'b0};

    logic [COORD_W-1:0] h_count, v_count;
    logic               mode_active;
    logic [COORD_W-1:0] h_pix, h_ss, h_se, h_last;
    logic [COORD_W-1:0] v_pix, v_ss, v_se, v_last;
    logic               h_pol, v_pol;
    logic               at_h_last, frame_wrap;
    stage_t             s0;
    stage_t             pipe_q [PD+1];
    stage_t             disp;
    logic [15:0]        frame_count;

    // Select the timing constants of the mode the counters are running.
    always_comb begin
        if (mode_active) begin
            h_pix = B_HPX; h_ss = B_HSS; h_se = B_HSE; h_last = B_HLS; h_pol = B_H_POL;
            v_pix = B_VPX; v_ss = B_VSS; v_se = B_VSE; v_last = B_VLS; v_pol = B_V_POL;
        end else begin
            h_pix = A_HPX; h_ss = A_HSS; h_se = A_HSE; h_last = A_HLS; h_pol = A_H_POL;
            v_pix = A_VPX; v_ss = A_VSS; v_se = A_VSE; v_last = A_VLS; v_pol = A_V_POL;
        end
    end

    assign at_h_last  = (h_count == h_last);
    assign frame_wrap = at_h_last && (v_count == v_last);

    // Raster counters; mode only changes at the frame wrap or while stopped.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            h_count     <= '0;
            v_count     <= '0;
            mode_active <= 1'b0;
        end else if (!vga.enable) begin
            h_count     <= '0;
            v_count     <= '0;
            mode_active <= vga.mode_sel;
        end else begin
            if (at_h_last) begin
                h_count <= '0;
                v_count <= (v_count == v_last) ? '0 : v_count + COORD_W'(1);
            end else begin
                h_count <= h_count + COORD_W'(1);
            end
            if (frame_wrap) mode_active <= vga.mode_sel;
        end
    end

    // Stage-0 decode of the counters; idle values while stopped.
    always_comb begin
        s0       = '0;
        s0.hs    = ~h_pol;
        s0.vs    = ~v_pol;
        if (vga.enable) begin
            s0.valid = (h_count < h_pix) && (v_count < v_pix);
            s0.x     = (h_count < h_pix) ? h_count : '0;
            s0.y     = (v_count < v_pix) ? v_count : '0;
            s0.hs    = (h_count >= h_ss && h_count <= h_se) ? h_pol : ~h_pol;
            s0.vs    = (v_count >= v_ss && v_count <= v_se) ? v_pol : ~v_pol;
            s0.ls    = (h_count == '0) && (v_count < v_pix);
            s0.fs    = (h_count == '0) && (v_count == '0);
        end
    end

    // Fetch register (index 0) followed by PIPE_DELAY display-alignment registers.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= PD; i++) pipe_q[i] <= RST_STAGE;
        end else begin
            pipe_q[0] <= s0;
            for (int i = 1; i <= PD; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign disp = pipe_q[PD];

    // Count frames one cycle after each display frame_start pulse.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) frame_count <= '0;
        else if (disp.fs) frame_count <= frame_count + 16'd1;
    end

    assign vga.mode_active = mode_active;
    assign vga.fetch_valid = pipe_q[0].valid;
    assign vga.fetch_x     = pipe_q[0].x;
    assign vga.fetch_y     = pipe_q[0].y;
    assign vga.disp_ena    = disp.valid;
    assign vga.column      = disp.x;
    assign vga.row         = disp.y;
    assign vga.h_sync      = disp.hs;
    assign vga.v_sync      = disp.vs;
    assign vga.line_start  = disp.ls;
    assign vga.frame_start = disp.fs;
    assign vga.frame_count = frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using shrunken modes so whole frames fit in a short run.
// Mode A: H 8/2/3/2 (15), V 4/1/2/1 (8), active-low syncs, 120-cycle frame.
// Mode B: H 10/1/2/3 (16), V 5/2/1/2 (10), active-high syncs, 160-cycle frame.
module tb_vga_timing_gen;
    logic pixel_clk;
    logic reset;

    vga_timing_gen_if #(.COORD_W(11)) vga ();

    vga_timing_gen #(
        .COORD_W(11), .PIPE_DELAY(3),
        .A_H_PIX(8),  .A_H_FP(2), .A_H_PULSE(3), .A_H_BP(2),
        .A_V_PIX(4),  .A_V_FP(1), .A_V_PULSE(2), .A_V_BP(1),
        .A_H_POL(1'b0), .A_V_POL(1'b0),
        .B_H_PIX(10), .B_H_FP(1), .B_H_PULSE(2), .B_H_BP(3),
        .B_V_PIX(5),  .B_V_FP(2), .B_V_PULSE(1), .B_V_BP(2),
        .B_H_POL(1'b1), .B_V_POL(1'b1)
    ) dut (
        .pixel_clk(pixel_clk),
        .reset(reset),
        .vga(vga)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    // Three-cycle ROM whose data is just the requested x address.
    logic [10:0] rom_q [3];
    always_ff @(posedge pixel_clk) begin
        rom_q[0] <= vga.fetch_x;
        rom_q[1] <= rom_q[0];
        rom_q[2] <= rom_q[1];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int tot_fs   = 0;
    int tot_ls   = 0;
    int idx, w_de, w_hs_hi, w_vs_hi, w_ls, w_fs, w_mism, first_hs, first_vs;
    int ls_pos [2];
    logic hs_base, vs_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample_acc();
        if (vga.disp_ena) w_de++;
        if (vga.h_sync) w_hs_hi++;
        if (vga.v_sync) w_vs_hi++;
        if (vga.frame_start) w_fs++;
        if (vga.line_start) begin
            if (w_ls < 2) ls_pos[w_ls] = idx;
            w_ls++;
        end
        if (vga.disp_ena && rom_q[2] !== vga.column) w_mism++;
        if (first_hs < 0 && vga.h_sync !== hs_base) first_hs = idx;
        if (first_vs < 0 && vga.v_sync !== vs_base) first_vs = idx;
        idx++;
    endtask

    task automatic clear_acc();
        idx = 0; w_de = 0; w_hs_hi = 0; w_vs_hi = 0; w_ls = 0; w_fs = 0; w_mism = 0;
        first_hs = -1; first_vs = -1; ls_pos[0] = -1; ls_pos[1] = -1;
        hs_base = vga.h_sync; vs_base = vga.v_sync;
        sample_acc();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge pixel_clk);
            if (!reset) begin
                if (vga.frame_start) tot_fs++;
                if (vga.line_start) tot_ls++;
            end
            sample_acc();
        end
    endtask

    initial begin
        reset = 1'b1; vga.enable = 1'b1; vga.mode_sel = 1'b0;
        clear_acc();
        tick(2);
        check("rst_hsync", vga.h_sync, 1);
        check("rst_vsync", vga.v_sync, 1);
        check("rst_de", vga.disp_ena, 0);
        check("rst_fvalid", vga.fetch_valid, 0);
        check("rst_mode", vga.mode_active, 0);
        check("rst_fcount", vga.frame_count, 0);
        reset = 1'b0;

        // First fetch after one edge, first display pixel after 1+3 edges.
        tick(1);
        check("e1_fvalid", vga.fetch_valid, 1);
        check("e1_fx", vga.fetch_x, 0);
        check("e1_fy", vga.fetch_y, 0);
        check("e1_de", vga.disp_ena, 0);
        tick(3);
        check("e4_de", vga.disp_ena, 1);
        check("e4_fs", vga.frame_start, 1);
        check("e4_ls", vga.line_start, 1);
        check("e4_col", vga.column, 0);
        check("e4_hsync", vga.h_sync, 1);

        // Full mode A frame.
        clear_acc();
        tick(119);
        check("a_de_cycles", w_de, 32);
        check("a_hs_hi", w_hs_hi, 96);
        check("a_vs_hi", w_vs_hi, 90);
        check("a_ls", w_ls, 4);
        check("a_fs", w_fs, 1);
        check("a_hs_start", first_hs, 10);
        check("a_vs_start", first_vs, 75);
        check("a_line_period", ls_pos[1], 15);
        check("a_rom_align", w_mism, 0);
        check("a_fcount", vga.frame_count, 1);
        tick(1);
        check("a2_fs", vga.frame_start, 1);
        tick(1);
        check("a2_fcount", vga.frame_count, 2);

        // Request mode B mid-frame; it takes effect at the counter wrap (edge 240).
        vga.mode_sel = 1'b1;
        check("sw_mode_hold0", vga.mode_active, 0);
        tick(114);
        check("sw_mode_hold1", vga.mode_active, 0);
        tick(1);
        check("sw_mode_new", vga.mode_active, 1);
        tick(3);
        check("sw_last_a_hs", vga.h_sync, 1);
        check("sw_last_a_vs", vga.v_sync, 1);
        tick(1);
        check("b_fs", vga.frame_start, 1);
        check("b_de", vga.disp_ena, 1);
        check("b_hs_idle", vga.h_sync, 0);
        check("b_vs_idle", vga.v_sync, 0);

        // Full mode B frame.
        clear_acc();
        tick(159);
        check("b_de_cycles", w_de, 50);
        check("b_hs_hi", w_hs_hi, 20);
        check("b_vs_hi", w_vs_hi, 16);
        check("b_ls", w_ls, 5);
        check("b_fs_cnt", w_fs, 1);
        check("b_hs_start", first_hs, 11);
        check("b_vs_start", first_vs, 112);
        check("b_line_period", ls_pos[1], 16);
        check("b_rom_align", w_mism, 0);
        check("b_fcount", vga.frame_count, 3);
        check("tot_fs", tot_fs, 3);
        check("tot_ls", tot_ls, 13);
        tick(1);
        check("b2_fs", vga.frame_start, 1);
        tick(37);
        check("b2_col", vga.column, 5);
        check("b2_row", vga.row, 2);
        check("b2_de", vga.disp_ena, 1);

        // Asynchronous reset mid-frame.
        #2 reset = 1'b1;
        #1;
        check("ar_de", vga.disp_ena, 0);
        check("ar_hsync", vga.h_sync, 1);
        check("ar_vsync", vga.v_sync, 1);
        check("ar_col", vga.column, 0);
        check("ar_row", vga.row, 0);
        check("ar_fvalid", vga.fetch_valid, 0);
        check("ar_mode", vga.mode_active, 0);
        check("ar_fcount", vga.frame_count, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("ar_no_early_de", vga.disp_ena, 0);
        tick(1);
        check("ar_restart_fs", vga.frame_start, 1);
        check("ar_restart_mode", vga.mode_active, 0);
        check("ar_restart_hs", vga.h_sync, 1);
        vga.mode_sel = 1'b0;

        // Drop enable mid-line.
        tick(2);
        vga.enable = 1'b0;
        tick(1);
        check("en_fvalid", vga.fetch_valid, 0);
        tick(2);
        check("en_de_still", vga.disp_ena, 1);
        tick(1);
        check("en_de_idle", vga.disp_ena, 0);
        check("en_hs_idle", vga.h_sync, 1);
        check("en_vs_idle", vga.v_sync, 1);
        tick(990);
        check("en_long_de", vga.disp_ena, 0);
        check("en_long_fs", vga.frame_start, 0);
        vga.mode_sel = 1'b1;
        tick(1);
        check("en_mode_follow", vga.mode_active, 1);
        tick(5);
        check("en_b_hs_idle", vga.h_sync, 0);
        check("en_b_vs_idle", vga.v_sync, 0);
        vga.enable = 1'b1;
        tick(1);
        check("re_fvalid", vga.fetch_valid, 1);
        tick(2);
        check("re_fs_early", vga.frame_start, 0);
        tick(1);
        check("re_fs", vga.frame_start, 1);
        check("re_de", vga.disp_ena, 1);
        tick(1);
        check("re_fcount", vga.frame_count, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Two-mode, parametrised VGA timing generator for the display path. It runs on `pixel_clk` and produces sync, display-enable and pixel coordinates for one of two compile-time video modes, selectable at runtime and switched only at frame boundaries. It adds a lookahead fetch port so a framebuffer or ROM with `PIPE_DELAY` cycles of read latency returns pixel data aligned with `disp_ena`. It also provides line/frame strobes and a frame counter for animation logic.

## Interface
- `COORD_W`, 11, width of the counters and of every coordinate output; must hold max(total H, total V) − 1.
- `PIPE_DELAY`, 1, extra cycles (0..4) between the fetch outputs and the display outputs.
- `A_H_PIX/A_H_FP/A_H_PULSE/A_H_BP`, 640/16/96/48, mode A horizontal active, front porch, sync and back porch.
- `A_V_PIX/A_V_FP/A_V_PULSE/A_V_BP`, 480/10/2/33, mode A vertical active, front porch, sync and back porch.
- `A_H_POL/A_V_POL`, 0/0, mode A sync polarity (1 = active-high).
- `B_H_PIX/B_H_FP/B_H_PULSE/B_H_BP`, 800/56/120/64, mode B horizontal timing.
- `B_V_PIX/B_V_FP/B_V_PULSE/B_V_BP`, 600/37/6/23, mode B vertical timing.
- `B_H_POL/B_V_POL`, 1/1, mode B sync polarity.

Ports:
- `pixel_clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = run; 0 = hold counters at origin and blank.
- `mode_sel`  in  1  requested mode (0 = A, 1 = B).
- `mode_active`  out  1  mode currently in use by the counters.
- `fetch_valid`  out  1  fetch coordinates are in the active area.
- `fetch_x`, `fetch_y`  out  COORD_W each  lookahead pixel coordinates.
- `h_sync`, `v_sync`  out  1 each  sync outputs at the mode's polarity.
- `disp_ena`  out  1  display enable.
- `column`, `row`  out  COORD_W each  display coordinates.
- `line_start`  out  1  one-cycle strobe, display-aligned, at the first pixel of each active line.
- `frame_start`  out  1  one-cycle strobe, display-aligned, at pixel (0,0).
- `frame_count`  out  16  number of frames started; wraps.

## Operation
- Internal `h_count` and `v_count` are COORD_W bits wide. Per mode:
  - H_TOT = PIX + FP + PULSE + BP.
  - Line order: active, front porch, sync, back porch.
- Counting:
  - `h_count` wraps at H_TOT−1.
  - `v_count` advances on each h wrap and wraps at V_TOT−1.
- Stage-0 signals, decoded combinationally from the counters:
  - active = h<H_PIX && v<V_PIX.
  - hs_act when H_PIX+H_FP ≤ h ≤ H_PIX+H_FP+H_PULSE−1 (exactly H_PULSE cycles). vs_act is the same rule on v.
  - Sync output = POL when active, else ~POL.
  - x = h if h<H_PIX else 0; y = v if v<V_PIX else 0.
  - ls = (h==0 && v<V_PIX); fs = (h==0 && v==0).
- Fetch stage: stage-0 signals are registered once into `fetch_valid`, `fetch_x`, `fetch_y`.
- Display stage: all fetch-stage signals pass through PIPE_DELAY further registers to `disp_ena`, `column`, `row`, `h_sync`, `v_sync`, `line_start`, `frame_start`. With PIPE_DELAY=0, display signals equal fetch signals.
- `frame_count` increments on the cycle after each display `frame_start` pulse; it wraps 65535→0.
- Mode switching:
  - `mode_sel` is sampled into `mode_active` only on the cycle the counters wrap from (H_TOT−1, V_TOT−1) to (0,0), or on any cycle while `enable`=0.
  - The new mode's timing and polarity apply from count (0,0). No partial frames.
- `enable`=0:
  - Counters are forced to (0,0).
  - Stage 0 is fed idle values: syncs inactive for `mode_active`, active/ls/fs = 0, coords 0.
  - The pipeline keeps shifting, so idle values reach the display after the normal latency.
- `enable` 0→1: counting starts at (0,0) on the next edge.

## Timing
- Reset values:
  - Counters 0, `mode_active`=0.
  - All pipeline registers idle: `h_sync`=~A_H_POL, `v_sync`=~A_V_POL, `disp_ena`=0, `fetch_valid`=0, coords 0, strobes 0.
  - `frame_count`=0.
- Reset mid-frame clears everything immediately (asynchronous). No residual pulses after release.
- Latency: counter → fetch outputs is 1 cycle; counter → display outputs is 1+PIPE_DELAY cycles.
- After reset release with `enable`=1:
  - Edge 1: `fetch_valid`=1, `fetch_x`=`fetch_y`=0.
  - Edge 1+PIPE_DELAY: `disp_ena`=1, `frame_start`=1.
- Line period H_TOT cycles; frame period H_TOT×V_TOT cycles (mode A 800×525 = 420000; mode B 1040×666 = 692640).
- A polarity change on a mode switch appears at the display outputs 1+PIPE_DELAY cycles after the wrap.

## Test plan
- Mode A, PIPE_DELAY=1, reset then run one frame:
  - `h_sync` low for exactly 96 cycles per line, starting 656 cycles after `disp_ena` rises.
  - `v_sync` low for 2 lines starting at line 490.
  - `disp_ena` high 640 cycles/line for 480 lines.
- Lookahead alignment with PIPE_DELAY=3: model a 3-cycle ROM returning `fetch_x`. Returned data equals `column` on every `disp_ena` cycle.
- Assert `mode_sel`=1 mid-frame:
  - `mode_active` stays 0 until the frame wrap, then becomes 1.
  - The next frame has 1040-cycle lines, positive 120-cycle `h_sync` and `v_sync` high for 6 lines.
- Strobes and counter: run 3 frames. Exactly 3 `frame_start` pulses, 480 `line_start` pulses per frame, and `frame_count`=3.
- Assert `reset` at h=300, v=200: all outputs reach reset values asynchronously. After release, timing restarts from (0,0).
- Pull `enable`=0 for 1000 cycles mid-line:
  - 1+PIPE_DELAY cycles after the fall, the display outputs go idle (`disp_ena`=0, syncs inactive).
  - After `enable` returns to 1, `frame_start` recurs 1+PIPE_DELAY cycles later.
